// File: rtl/btn_cond_pkg.sv
// Shared types and widths for the button conditioner channels.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int CNT_W = 4;
    localparam int REP_W = 16;

    // The debounced level is high while pressed or while a release is still being qualified.
    function automatic logic is_down(input btn_state_t s);
        return (s == PRESSED) || (s == RELEASE_PEND);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, tick-sampled debounce FSM, registered level/press/release.
// Latency: 2 clk sync + tick alignment + (STABLE_CNT-1) ticks + 1 clk output register.
// Backpressure: none; pulses are one clk wide. BTN_COND_REPEAT_EN adds press auto-repeat while held.
module btn_chan
    import btn_cond_pkg::*;
#(
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             sync_1;
    logic             btn_sync;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             down;
    logic             rep_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync_1   <= btn_raw;
            btn_sync <= sync_1;
        end
    end

    // cnt holds the length of the current run of samples that disagree with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RELEASED;
            cnt   <= '0;
        end else if (tick) begin
            case (state)
                RELEASED: begin
                    if (btn_sync) begin
                        state <= PRESS_PEND;
                        cnt   <= CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!btn_sync) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state <= RELEASE_PEND;
                        cnt   <= CNT_W'(1);
                    end
                end
                RELEASE_PEND: begin
                    if (btn_sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef BTN_COND_REPEAT_EN
    localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
    logic [REP_W-1:0] rep_tgt;

    // First interval is the initial delay, every later one is the repeat period.
    assign rep_tgt = rep_armed ? REP_PER : REP_DLY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_hit   <= 1'b0;
        end else begin
            rep_hit <= 1'b0;
            if (!is_down(state)) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (tick && state == PRESSED && btn_sync) begin
                if (rep_cnt + 1'b1 == rep_tgt) begin
                    rep_hit   <= 1'b1;
                    rep_cnt   <= '0;
                    rep_armed <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    assign down = is_down(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= down;
            btn_press   <= (down & ~btn_level) | rep_hit;
            btn_release <= ~down & btn_level;
        end
    end

endmodule

// File: rtl/btn_cond.sv
// Multi-channel push-button conditioner: shared sample prescaler feeding N_BTN independent channels.
// Latency: raw edge to level 3 clk + up to STABLE_CNT*SAMPLE_DIV clk; press/release pulse with the level edge.
// Backpressure: none; outputs are free-running. Define BTN_COND_REPEAT_EN for press auto-repeat.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int SAMPLE_DIV   = 50000,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_pressed
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

    assign any_pressed = |btn_level;

endmodule

// File: tb/tb_btn_cond.sv
// Directed scenarios plus random button activity, checked every cycle against a sample-run reference model.
module tb_btn_cond;

    localparam int N     = 4;
    localparam int SDIV  = 4;
    localparam int SCNT  = 3;
    localparam int RDLY  = 5;
    localparam int RRATE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_pressed;

    btn_cond #(
        .N_BTN       (N),
        .SAMPLE_DIV  (SDIV),
        .STABLE_CNT  (SCNT),
        .REPEAT_DELAY(RDLY),
        .REPEAT_RATE (RRATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: accepted level flips after SCNT consecutive disagreeing samples.
    int           m_cyc;
    logic [N-1:0] m_acc, m_lvl, m_prs, m_rel, m_fire, m_d1, m_d2;
    int           m_run  [N];
    int           m_held [N];

    int           press_seen [N];
    int           rel_seen   [N];
    int           rise_seen  [N];
    int           lvl_seen   [N];
    logic [N-1:0] prev_lvl = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_acc  = '0;
        m_lvl  = '0;
        m_prs  = '0;
        m_rel  = '0;
        m_fire = '0;
        m_d1   = '0;
        m_d2   = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic         tick;
        logic [N-1:0] nxt_fire;
        tick     = (m_cyc % SDIV) == (SDIV - 1);
        m_prs    = (m_acc & ~m_lvl) | m_fire;
        m_rel    = ~m_acc & m_lvl;
        m_lvl    = m_acc;
        nxt_fire = '0;
        if (tick) begin
            for (int c = 0; c < N; c++) begin
                if (m_d2[c] != m_acc[c]) begin
                    m_run[c]++;
                    if (m_run[c] == SCNT) begin
                        m_acc[c]  = m_d2[c];
                        m_run[c]  = 0;
                        m_held[c] = 0;
                    end
                end else begin
                    if (m_acc[c] && m_run[c] == 0) begin
                        m_held[c]++;
`ifdef BTN_COND_REPEAT_EN
                        if (m_held[c] == RDLY || (m_held[c] > RDLY && (m_held[c] - RDLY) % RRATE == 0))
                            nxt_fire[c] = 1'b1;
`endif
                    end
                    m_run[c] = 0;
                end
            end
        end
        m_fire = nxt_fire;
        m_d2   = m_d1;
        m_d1   = btn_raw;
        m_cyc++;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            press_seen[c] = 0;
            rel_seen[c]   = 0;
            rise_seen[c]  = 0;
            lvl_seen[c]   = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        chk("level", 32'(btn_level), 32'(m_lvl));
        chk("press", 32'(btn_press), 32'(m_prs));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("any_pressed", 32'(any_pressed), 32'(|m_lvl));
        for (int c = 0; c < N; c++) begin
            if (btn_press[c]) press_seen[c]++;
            if (btn_release[c]) rel_seen[c]++;
            if (btn_level[c]) lvl_seen[c]++;
            if (btn_press[c] && btn_level[c] && !prev_lvl[c]) rise_seen[c]++;
        end
        prev_lvl = btn_level;
    endtask

    int lat;
    int tmr [N];
    int exp_rep;

    initial begin
        model_reset();
        clear_counts();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_level", 32'(btn_level), 32'(0));
        chk("reset_pulses", 32'({btn_press, btn_release}), 32'(0));
        chk("reset_any", 32'(any_pressed), 32'(0));
        model_reset();
        rst = 1'b0;
        repeat (5) step();

        // Clean press on channel 0
        clear_counts();
        btn_raw[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 28; k++) begin
            step();
            if (lat == 0 && btn_level[0]) lat = k;
        end
        chk("clean_latency_window", 32'(lat >= 11 && lat <= 15), 32'(1));
        chk("clean_press_count", 32'(press_seen[0]), 32'(1));
        chk("clean_other_press", 32'(press_seen[1] + press_seen[2] + press_seen[3]), 32'(0));
        btn_raw[0] = 1'b0;
        repeat (25) step();
        chk("clean_released", 32'(btn_level[0]), 32'(0));

        // Bounce on channel 1
        clear_counts();
        for (int t = 0; t < 10; t++) begin
            btn_raw[1] = ~btn_raw[1];
            repeat (3) step();
        end
        btn_raw[1] = 1'b1;
        repeat (30) step();
        chk("bounce_press_count", 32'(rise_seen[1]), 32'(1));
        chk("bounce_no_release", 32'(rel_seen[1]), 32'(0));
        btn_raw[1] = 1'b0;
        repeat (25) step();

        // Glitch on channel 2
        clear_counts();
        btn_raw[2] = 1'b1;
        repeat (7) step();
        btn_raw[2] = 1'b0;
        repeat (25) step();
        chk("glitch_level_never", 32'(lvl_seen[2]), 32'(0));
        chk("glitch_no_pulses", 32'(press_seen[2] + rel_seen[2]), 32'(0));

        // Press then release on channel 3
        clear_counts();
        btn_raw[3] = 1'b1;
        repeat (40) step();
        chk("hold_any_pressed", 32'(any_pressed), 32'(1));
        btn_raw[3] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (lat == 0 && btn_release[3]) lat = k;
        end
        chk("release_latency_window", 32'(lat >= 11 && lat <= 15), 32'(1));
        chk("release_press_count", 32'(rise_seen[3]), 32'(1));
        chk("release_pulse_count", 32'(rel_seen[3]), 32'(1));
        chk("release_any_clear", 32'(any_pressed), 32'(0));

        // Asynchronous reset while channel 0 is held
        btn_raw[0] = 1'b1;
        repeat (30) step();
        chk("held_before_rst", 32'(btn_level[0]), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_level", 32'(btn_level), 32'(0));
        chk("rst_async_pulses", 32'({btn_press, btn_release, any_pressed}), 32'(0));
        model_reset();
        repeat (3) step();
        model_reset();
        rst = 1'b0;
        clear_counts();
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            step();
            if (btn_press[0]) lat = k;
        end
        chk("requal_press_seen", 32'(lat >= 11 && lat <= 15), 32'(1));

        // Keep holding: 20 ticks counted from PRESSED entry
        repeat (79) step();
`ifdef BTN_COND_REPEAT_EN
        exp_rep = 9;
`else
        exp_rep = 1;
`endif
        chk("repeat_press_count", 32'(press_seen[0]), 32'(exp_rep));
        chk("requal_no_release", 32'(rel_seen[0]), 32'(0));
        btn_raw[0] = 1'b0;
        repeat (25) step();

        // Random activity on all channels
        for (int c = 0; c < N; c++) tmr[c] = $urandom_range(1, 24);
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++) begin
                tmr[c]--;
                if (tmr[c] == 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    tmr[c]     = $urandom_range(1, 24);
                end
            end
            step();
        end
        btn_raw = '0;
        repeat (30) step();
        chk("final_idle", 32'(btn_level), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
